// File: rtl/gemm_seq_pkg.sv
// gemm_seq_pkg: register map, FSM states and tile-dimension packing shared by the gemm tile sequencer.
package gemm_seq_pkg;

    localparam logic [31:0] OFF_A    = 32'd0;
    localparam logic [31:0] OFF_B    = 32'd4;
    localparam logic [31:0] OFF_C    = 32'd8;
    localparam logic [31:0] OFF_ASTR = 32'd12;
    localparam logic [31:0] OFF_BSTR = 32'd16;
    localparam logic [31:0] OFF_CTRL = 32'd20;
    localparam logic [31:0] OFF_DIM  = 32'd24;
    localparam logic [31:0] OFF_FULL = 32'd0;
    localparam logic [31:0] OFF_DONE = 32'd24;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ASTR,
        S_WR_BSTR,
        S_WR_A,
        S_WR_B,
        S_WR_C,
        S_WR_CTRL,
        S_WR_DIM,
        S_POLL_FULL,
        S_WAIT_FULL,
        S_ADVANCE,
        S_POLL_DONE,
        S_WAIT_DONE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [4:0] nsize;
        logic [4:0] ksize;
        logic [4:0] msize;
    } dims_t;

    function automatic logic [31:0] pack_dims(input dims_t d);
        return {17'd0, d};
    endfunction

    // Shift-add product with a 5-bit factor; tile sizes never exceed 31.
    function automatic logic [31:0] mul5(input logic [31:0] x, input logic [4:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r = r + (s[i] ? x << i : 32'd0);
        return r;
    endfunction

endpackage

// File: rtl/gemm_tile_sequencer_index_gen.sv
// gemm_tile_index_gen: walks the n/m/k tile nest and produces tile offsets, sizes, first/last and wrap flags.
module gemm_tile_index_gen
    import gemm_seq_pkg::*;
#(
    parameter int BLK_N = 16,
    parameter int BLK_K = 16,
    parameter int BLK_M = 16,
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             step,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_n,
    output logic [DIM_W-1:0] k_dim,
    output logic [DIM_W-1:0] n_dim,
    output logic [31:0]      a_off,
    output logic [31:0]      b_off,
    output logic [31:0]      c_off,
    output dims_t            dims,
    output logic             first,
    output logic             last,
    output logic             all_wrap
);

    logic [DIM_W-1:0] dm_q, dm_d, dk_q, dk_d, dn_q, dn_d;
    logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [31:0]      a_row_q, a_row_d, b_row_q, b_row_d, c_row_q, c_row_d;
    logic [DIM_W-1:0] m_rem, k_rem, n_rem;
    logic             m_wrap, n_wrap;

    assign m_rem    = dm_q - m_q;
    assign k_rem    = dk_q - k_q;
    assign n_rem    = dn_q - n_q;
    assign last     = k_rem <= DIM_W'(BLK_K);
    assign m_wrap   = m_rem <= DIM_W'(BLK_M);
    assign n_wrap   = n_rem <= DIM_W'(BLK_N);
    assign first    = k_q == '0;
    assign all_wrap = last && m_wrap && n_wrap;
    assign k_dim    = dk_q;
    assign n_dim    = dn_q;
    assign dims     = '{nsize: n_wrap ? n_rem[4:0] : 5'(BLK_N),
                        ksize: last   ? k_rem[4:0] : 5'(BLK_K),
                        msize: m_wrap ? m_rem[4:0] : 5'(BLK_M)};
    assign a_off    = a_row_q + 32'(k_q);
    assign c_off    = c_row_q + 32'(n_q);
    // b_row tracks k*N; the tile address points at its last row, k+ksize-1.
    assign b_off    = b_row_q + mul5(32'(dn_q), dims.ksize - 5'd1) + 32'(n_q);

    always_comb begin
        dm_d    = init ? dim_m : dm_q;
        dk_d    = init ? dim_k : dk_q;
        dn_d    = init ? dim_n : dn_q;
        k_d     = k_q;
        m_d     = m_q;
        n_d     = n_q;
        a_row_d = a_row_q;
        b_row_d = b_row_q;
        c_row_d = c_row_q;
        if (init) begin
            k_d     = '0;
            m_d     = '0;
            n_d     = '0;
            a_row_d = '0;
            b_row_d = '0;
            c_row_d = '0;
        end else if (step) begin
            k_d     = last ? '0 : k_q + DIM_W'(BLK_K);
            b_row_d = last ? '0 : b_row_q + mul5(32'(dn_q), 5'(BLK_K));
            if (last) begin
                m_d     = m_wrap ? '0 : m_q + DIM_W'(BLK_M);
                a_row_d = m_wrap ? '0 : a_row_q + mul5(32'(dk_q), 5'(BLK_M));
                c_row_d = m_wrap ? '0 : c_row_q + mul5(32'(dn_q), 5'(BLK_M));
                n_d     = m_wrap ? n_q + DIM_W'(BLK_N) : n_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_q    <= '0;
            dk_q    <= '0;
            dn_q    <= '0;
            k_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            a_row_q <= '0;
            b_row_q <= '0;
            c_row_q <= '0;
        end else begin
            dm_q    <= dm_d;
            dk_q    <= dk_d;
            dn_q    <= dn_d;
            k_q     <= k_d;
            m_q     <= m_d;
            n_q     <= n_d;
            a_row_q <= a_row_d;
            b_row_q <= b_row_d;
            c_row_q <= c_row_d;
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: programs the gemm block tile by tile over the system bus for one full-matrix job.
module gemm_tile_sequencer
    import gemm_seq_pkg::*;
#(
    parameter int          BLK_N     = 16,
    parameter int          BLK_K     = 16,
    parameter int          BLK_M     = 16,
    parameter int          DIM_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [31:0]      a_base,
    input  logic [31:0]      b_base,
    input  logic [31:0]      c_base,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted,
    output logic [31:0]      tile_count,
    output logic [31:0]      cycle_count,
    output logic             bus_en,
    output logic             bus_rdwr,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wr_data,
    input  logic [31:0]      bus_rd_data
);

    state_e           state_q, state_d;
    logic [31:0]      a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic [31:0]      tile_count_q, tile_count_d, cycle_count_q, cycle_count_d;
    logic             err_q, err_d, aborted_q, aborted_d;
    logic             zero_dim, accept, in_busy, rd_flag, unused_rd;
    logic [DIM_W-1:0] k_dim, n_dim;
    logic [31:0]      a_off, b_off, c_off, off;
    dims_t            dims;
    logic             first, last, all_wrap;

    assign zero_dim  = dim_m == '0 || dim_k == '0 || dim_n == '0;
    assign accept    = state_q == S_IDLE && start && !abort && !zero_dim;
    assign in_busy   = state_q != S_IDLE && state_q != S_DONE;
    assign rd_flag   = bus_rd_data[0];
    assign unused_rd = ^bus_rd_data[31:1];

    gemm_tile_index_gen #(
        .BLK_N (BLK_N),
        .BLK_K (BLK_K),
        .BLK_M (BLK_M),
        .DIM_W (DIM_W)
    ) u_index (
        .clk      (clk),
        .rst      (rst),
        .init     (accept),
        .step     (state_q == S_ADVANCE),
        .dim_m    (dim_m),
        .dim_k    (dim_k),
        .dim_n    (dim_n),
        .k_dim    (k_dim),
        .n_dim    (n_dim),
        .a_off    (a_off),
        .b_off    (b_off),
        .c_off    (c_off),
        .dims     (dims),
        .first    (first),
        .last     (last),
        .all_wrap (all_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_busy && abort) state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE:      state_d = accept ? S_WR_ASTR : S_IDLE;
                S_WR_ASTR:   state_d = S_WR_BSTR;
                S_WR_BSTR:   state_d = S_WR_A;
                S_WR_A:      state_d = S_WR_B;
                S_WR_B:      state_d = S_WR_C;
                S_WR_C:      state_d = S_WR_CTRL;
                S_WR_CTRL:   state_d = S_WR_DIM;
                S_WR_DIM:    state_d = S_POLL_FULL;
                S_POLL_FULL: state_d = S_WAIT_FULL;
                S_WAIT_FULL: state_d = rd_flag ? S_POLL_FULL : S_ADVANCE;
                S_ADVANCE:   state_d = all_wrap ? S_POLL_DONE : S_WR_A;
                S_POLL_DONE: state_d = S_WAIT_DONE;
                S_WAIT_DONE: state_d = rd_flag ? S_DONE : S_POLL_DONE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        off         = OFF_FULL;
        bus_rdwr    = 1'b0;
        bus_wr_data = '0;
        case (state_q)
            S_WR_ASTR:   begin off = OFF_ASTR; bus_rdwr = 1'b1; bus_wr_data = 32'(k_dim); end
            S_WR_BSTR:   begin off = OFF_BSTR; bus_rdwr = 1'b1; bus_wr_data = 32'(n_dim); end
            S_WR_A:      begin off = OFF_A;    bus_rdwr = 1'b1; bus_wr_data = a_base_q + a_off; end
            S_WR_B:      begin off = OFF_B;    bus_rdwr = 1'b1; bus_wr_data = b_base_q + b_off; end
            S_WR_C:      begin off = OFF_C;    bus_rdwr = 1'b1; bus_wr_data = c_base_q + c_off; end
            S_WR_CTRL:   begin off = OFF_CTRL; bus_rdwr = 1'b1; bus_wr_data = {30'd0, first, last}; end
            S_WR_DIM:    begin off = OFF_DIM;  bus_rdwr = 1'b1; bus_wr_data = pack_dims(dims); end
            S_POLL_DONE: off = OFF_DONE;
            S_WAIT_DONE: off = OFF_DONE;
            default:     ;
        endcase
        bus_en   = in_busy;
        busy     = in_busy;
        done     = state_q == S_DONE;
        bus_addr = in_busy ? BASE_ADDR + off : '0;
    end

    always_comb begin
        a_base_d      = accept ? a_base : a_base_q;
        b_base_d      = accept ? b_base : b_base_q;
        c_base_d      = accept ? c_base : c_base_q;
        tile_count_d  = accept ? '0 : tile_count_q + 32'(state_q == S_WR_DIM);
        cycle_count_d = accept ? '0 : cycle_count_q + 32'(in_busy);
        err_d         = state_q == S_IDLE && start && !abort && zero_dim;
        aborted_d     = in_busy && abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_base_q      <= '0;
            b_base_q      <= '0;
            c_base_q      <= '0;
            tile_count_q  <= '0;
            cycle_count_q <= '0;
            err_q         <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            a_base_q      <= a_base_d;
            b_base_q      <= b_base_d;
            c_base_q      <= c_base_d;
            tile_count_q  <= tile_count_d;
            cycle_count_q <= cycle_count_d;
            err_q         <= err_d;
            aborted_q     <= aborted_d;
        end
    end

    assign tile_count  = tile_count_q;
    assign cycle_count = cycle_count_q;
    assign err         = err_q;
    assign aborted     = aborted_q;

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
- Hardware replacement for the software tiling loop that programs the gemm block over its system bus.
- Accepts one full-matrix job (M, K, N, three base addresses) and walks the tile nest in order n outer, m middle, k inner.
- For each tile it issues the configuration register writes, then stalls while gemm reports full.
- After the last tile it polls gemm done, then signals job completion with tile and cycle counts.

Parameters:
BLK_N, 16, tile width in N (super-array rows), 1..31
BLK_K, 16, tile depth in K (super-array cols), 1..31
BLK_M, 16, tile height in M, 1..31
DIM_W, 16, width of M/K/N job dimensions
BASE_ADDR, 32'h9000_0000, gemm register base on system bus

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle job start pulse; ignored unless idle
abort  in  1  one-cycle pulse; cancels the running job
dim_m, dim_k, dim_n  in  DIM_W each  job dimensions, sampled on start
a_base, b_base, c_base  in  32 each  element addresses, sampled on start
busy  out  1  job in progress
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse when start is given with any dimension = 0
aborted  out  1  one-cycle pulse when abort has taken effect
tile_count  out  32  tiles issued in current/last job
cycle_count  out  32  cycles from start accept to done
bus_en  out  1  system bus request
bus_rdwr  out  1  1 = write, 0 = read
bus_addr  out  32  system bus address
bus_wr_data  out  32  system bus write data
bus_rd_data  in  32  read data, valid the cycle after a read request

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Register map (byte offset from BASE_ADDR):
  - 0: write A tile addr; read returns the full flag.
  - 4: write B tile addr.
  - 8: write C tile addr.
  - 12: write A stride.
  - 16: write B stride.
  - 20: write control = {first, last} in bits [1:0].
  - 24: write dims = msize | ksize<<5 | nsize<<10; read returns the done flag.
- Bus timing: one access per cycle. bus_en is held 1 from start accept until DONE; bus_rdwr and bus_addr change only on FSM transitions.
- IDLE:
  - start with any dimension = 0: pulse err, stay in IDLE.
  - Otherwise latch all inputs, clear the counters, set busy, go to WR_ASTR.
- Stride writes: WR_ASTR writes K, then WR_BSTR writes N. Strides are written once per job, not per tile.
- Per-tile write sequence: WR_A, WR_B, WR_C, WR_CTRL, WR_DIM. Each state lasts one cycle.
- Tile sizes and flags:
  - msize = min(BLK_M, M-m); ksize = min(BLK_K, K-k); nsize = min(BLK_N, N-n).
  - first = (k==0); last = (k+BLK_K >= K).
- Tile addresses, all modulo 2^32:
  - A = a_base + m*K + k
  - B = b_base + (k+ksize-1)*N + n (last row of the B tile)
  - C = c_base + m*N + n
- Address arithmetic uses incremental offset registers (add K or N per step), not multipliers.
- tile_count increments on each WR_DIM.
- Full polling:
  - POLL_FULL issues a read of offset 0.
  - WAIT_FULL samples bus_rd_data[0]. If 1, return to POLL_FULL. If 0, go to ADVANCE.
- ADVANCE:
  - Step k by BLK_K. On wrap, reset k and step m by BLK_M. On m wrap, reset m and step n by BLK_N.
  - Next state is WR_A, or POLL_DONE when all indices have wrapped.
- Done polling:
  - POLL_DONE issues a read of offset 24.
  - WAIT_DONE samples bit 0. If 1, go to DONE. If 0, return to POLL_DONE.
- DONE: pulse done, drop busy and bus_en, freeze cycle_count, return to IDLE. tile_count is held until the next accepted start.
- cycle_count increments every cycle while busy.
- Abort:
  - In any busy state, abort finishes the current bus cycle, then deasserts bus_en, pulses aborted, returns to IDLE.
  - No done pulse is given.
  - abort and start in the same cycle while IDLE: start is ignored.
- start while busy is ignored. rst mid-job returns everything to reset values next cycle, with no bus access.
- Partial tiles are handled only through the size fields; no padding writes are issued.

Decomposition:
- Package gemm_seq_pkg holds:
  - the register offset constants;
  - the FSM state enum;
  - a packed dims struct {nsize[4:0], ksize[4:0], msize[4:0]} with a pack function.
- One sub-module, gemm_tile_index_gen: owns the m/k/n counters, offset registers, size/first/last generation and the wrap flags. The top level holds the FSM and bus drive.

Test Plan:
- Single tile: M=K=N=16, a/b/c_base = 0/256/512, full=0 → writes 16, 16, A=0, B=496, C=512, ctrl=3, dims=16912; then poll done=1 → done, tile_count=1.
- Partial tiles: M=K=N=20, bases 0/400/800 → 8 tiles. Tile (n=16, m=16, k=16) writes A=336, B=796, C=1136, ctrl=1, dims=4228. Tile (n=0, m=0, k=0) writes ctrl=2.
- Backpressure: full=1 for 5 reads after tile 1 → exactly 5 extra POLL/WAIT pairs, no offset-0 write until full reads 0; cycle_count grows by 10.
- Zero dimension: start with dim_k=0 → err pulse, bus_en stays 0, busy stays 0.
- Abort mid-job: abort during WR_B of tile 3 → that write completes, bus_en=0 next cycle, aborted pulse, no done; a later start runs a full job correctly.
- Reset mid-job: rst during POLL_FULL → all outputs 0 the next cycle; a fresh start gives the first-tile sequence again.
